// File: rtl/uart_transmitter.sv
// UART transmitter: byte FIFO feeding an 8-bit LSB-first serialiser with one stop bit.
// Define UART_TX_PARITY_EN to insert an even parity bit between data bit 7 and the stop bit.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data_in,
  input  logic                          tx_data_valid,
  output logic                          tx_ready,
  output logic                          io_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]    COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      count_q, count_d;
  logic                io_tx_q, io_tx_d;
  logic                busy_q, busy_d;
  logic                push, pop, baud_end;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  assign tx_ready   = (count_q != COUNT_FULL);
  assign push       = tx_data_valid && tx_ready;
  assign baud_end   = (baud_q == BAUD_LAST);
  assign io_tx      = io_tx_q;
  assign tx_busy    = busy_q;
  assign fifo_count = count_q;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Chain straight into the next start bit when more bytes are waiting.
        if (baud_end) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
      bit_d   = '0;
`ifdef UART_TX_PARITY_EN
      parity_d = ^mem_q[rd_ptr_q];
`endif
    end

    if (state_d != state_q || state_q == S_IDLE || baud_end) baud_d = '0;
    else                                                    baud_d = baud_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // The line is registered, so drive it from the state being entered.
    case (state_d)
      S_START:  io_tx_d = 1'b0;
      S_DATA:   io_tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: io_tx_d = parity_d;
`endif
      default:  io_tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      io_tx_q  <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      count_q  <= count_d;
      io_tx_q  <= io_tx_d;
      busy_q   <= busy_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
